// File: rtl/regbank_dump_ctrl.sv
// rtl/regbank_dump_ctrl.sv - debug dump of the register bank over a byte stream
// Halts the pipeline, borrows read port A and streams every register LSB byte first.
module regbank_dump_ctrl #(
  parameter int NB_DATA      = 32,
  parameter int NB_REG       = 5,
  parameter int NUM_REGS     = 32,
  parameter int NB_BYTE      = 8,
  parameter int HALT_TIMEOUT = 1023,
  parameter int NB_TIMEOUT   = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic               i_pipe_halted,
  input  logic [NB_DATA-1:0] i_rb_data,
  input  logic               i_tx_ready,
  output logic               o_halt_req,
  output logic               o_rb_sel,
  output logic [NB_REG-1:0]  o_rb_read_addr,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam int NUM_BYTES = NB_DATA / NB_BYTE;
  localparam int NB_BIDX   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [NB_REG-1:0]     LAST_REG  = NB_REG'(NUM_REGS - 1);
  localparam logic [NB_BIDX-1:0]    LAST_BYTE = NB_BIDX'(NUM_BYTES - 1);
  localparam logic [NB_TIMEOUT-1:0] LAST_WAIT = NB_TIMEOUT'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [NB_REG-1:0]     reg_idx;
  logic [NB_BIDX-1:0]    byte_idx;
  logic [NB_TIMEOUT-1:0] wait_cnt;
  logic [NB_DATA-1:0]    data_q;
  logic                  error_q;
  logic [NB_BYTE-1:0]    cur_byte;
  logic                  timeout;
  logic                  last_byte;
  logic                  last_reg;

  assign timeout   = (wait_cnt == LAST_WAIT);
  assign last_byte = (byte_idx == LAST_BYTE);
  assign last_reg  = (reg_idx == LAST_REG);

  always_comb begin
    cur_byte = '0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (byte_idx == NB_BIDX'(b)) cur_byte = data_q[b*NB_BYTE +: NB_BYTE];
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    o_halt_req = 1'b0;
    o_rb_sel   = 1'b0;
    o_tx_valid = 1'b0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_next = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        o_halt_req = 1'b1;
        if (i_pipe_halted) state_next = S_READ;
        else if (timeout)  state_next = S_IDLE;
      end
      S_READ: begin
        o_halt_req = 1'b1;
        o_rb_sel   = 1'b1;
        state_next = S_SEND;
      end
      S_SEND: begin
        o_halt_req = 1'b1;
        o_rb_sel   = 1'b1;
        o_tx_valid = 1'b1;
        if (i_tx_ready && last_byte) state_next = last_reg ? S_DONE : S_READ;
      end
      S_DONE: begin
        o_halt_req = 1'b1;
        o_rb_sel   = 1'b1;
        o_done     = !i_abort;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides every other exit, including a transfer or a timeout on the same edge.
    if (i_abort && state != S_IDLE) state_next = S_IDLE;
  end

  assign o_rb_read_addr = o_rb_sel ? reg_idx : '0;
  assign o_tx_data      = o_tx_valid ? cur_byte : '0;
  assign o_error        = error_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      reg_idx  <= '0;
      byte_idx <= '0;
      wait_cnt <= '0;
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        S_IDLE: begin
          reg_idx  <= '0;
          byte_idx <= '0;
          wait_cnt <= '0;
        end
        S_HALT_WAIT: begin
          wait_cnt <= wait_cnt + NB_TIMEOUT'(1);
          reg_idx  <= '0;
          if (!i_abort && !i_pipe_halted && timeout) error_q <= 1'b1;
        end
        S_READ: begin
          data_q   <= i_rb_data;
          byte_idx <= '0;
        end
        S_SEND: begin
          if (i_tx_ready && !i_abort) begin
            if (!last_byte)     byte_idx <= byte_idx + NB_BIDX'(1);
            else if (!last_reg) reg_idx  <= reg_idx + NB_REG'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regbank_dump_ctrl.md
Name: regbank_dump_ctrl

Overview:
Debug-side controller that shares read port A of the decode-stage register bank between the pipeline and the debug unit. On request it halts the pipeline, takes the read port, and reads all architectural registers in order. It serialises each register as bytes, LSB first, over a valid/ready byte stream toward the UART TX path. It then releases the port and the pipeline.

Parameters:
NB_DATA, 32, register width; must be a multiple of NB_BYTE
NB_REG, 5, register address width
NUM_REGS, 32, registers dumped (addresses 0..NUM_REGS-1)
NB_BYTE, 8, stream byte width
HALT_TIMEOUT, 1023, max cycles to wait for halt acknowledge
NB_TIMEOUT, 10, timeout counter width

Ports:
i_clock  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_start  in  1  dump request, sampled in IDLE only
i_abort  in  1  cancel dump; honoured in any non-IDLE state
i_pipe_halted  in  1  pipeline stalled/drained acknowledge
i_rb_data  in  NB_DATA  register bank read-port-A data (combinational from address)
i_tx_ready  in  1  byte sink ready
o_halt_req  out  1  pipeline halt request
o_rb_sel  out  1  1 = debug owns read port A mux
o_rb_read_addr  out  NB_REG  read address when o_rb_sel=1
o_tx_data  out  NB_BYTE  stream byte
o_tx_valid  out  1  stream byte valid
o_busy  out  1  high in every state except IDLE
o_done  out  1  1-cycle pulse, dump complete
o_error  out  1  1-cycle pulse, halt timeout

Behaviour:
- Reset (i_reset=0, async): state IDLE; all outputs 0; reg index, byte index, timeout counter and data latch cleared.
- States: IDLE, HALT_WAIT, READ, SEND, DONE.
- IDLE: i_start=1 -> HALT_WAIT; o_halt_req=1 from the next cycle. i_start in other states is ignored.
- HALT_WAIT:
  - o_halt_req=1; counter increments each cycle.
  - i_pipe_halted=1 -> READ; reg index=0.
  - Counter reaches HALT_TIMEOUT without ack -> IDLE; o_error pulses 1 cycle; o_halt_req drops.
- READ:
  - o_rb_sel=1; o_rb_read_addr=reg index.
  - i_rb_data is latched at the end of this cycle; byte index=0 -> SEND.
  - Latency: exactly 1 cycle per register.
- SEND:
  - o_rb_sel stays 1 and the address stays stable.
  - o_tx_data = latched data byte[byte index] (byte 0 = bits [NB_BYTE-1:0]); o_tx_valid=1.
  - A byte transfers on an edge where o_tx_valid && i_tx_ready. o_tx_data must not change while valid and not ready.
  - Each transfer increments byte index. After byte NB_DATA/NB_BYTE-1:
    - reg index < NUM_REGS-1 -> reg index+1 -> READ (o_tx_valid=0 for that READ cycle).
    - Otherwise -> DONE.
- DONE: o_done=1 for 1 cycle; o_halt_req, o_rb_sel drop next cycle -> IDLE.
- i_abort=1 in any non-IDLE state -> IDLE next edge. Effects:
  - o_halt_req, o_rb_sel, o_tx_valid -> 0.
  - No o_done, no o_error.
  - Abort takes priority over a simultaneous transfer or timeout.
- i_pipe_halted dropping after READ is entered is ignored.
- Reg index never wraps; the index counter holds NUM_REGS-1 max.
- Reset mid-dump: immediate return to reset values. No partial-state recovery; the next dump restarts at register 0.
- Total bytes per dump: NUM_REGS*NB_DATA/NB_BYTE (128 by default).

Test Plan:
- Reset mid-SEND (drive i_reset=0 asynchronously) -> all outputs 0 within the same cycle. Then i_start -> first byte comes from register 0.
- Bank preloaded with reg k = 0x11223300+k; i_start; i_pipe_halted after 3 cycles; i_tx_ready=1 -> 128 bytes in order 0x00,0x33,0x22,0x11,0x01,0x33,... Final byte 0x11; o_done pulses once; o_busy falls the cycle after.
- Same dump with i_tx_ready toggling 1-in-3 -> identical byte sequence. o_tx_data is stable whenever valid and not ready; no byte is duplicated or lost.
- i_start, i_pipe_halted held 0 -> o_error pulses after 1023 HALT_WAIT cycles. o_halt_req=0 the next cycle; no tx bytes.
- i_abort asserted on the cycle after reg 5 byte 2 transfers (i_tx_ready=1) -> IDLE. o_tx_valid, o_rb_sel, o_halt_req=0; no o_done. A new i_start restarts at reg 0.
- i_start pulsed again during SEND -> ignored; byte count stays 128 and o_done pulses once.
